// File: rtl/dot_scene_sequencer_pkg.sv
// Shared types and default sizing for the dot-matrix scene sequencer.
// Mode encodings are the values presented on the `mode` output.
package dot_scene_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_PAUSED = 2'd2
    } mode_e;

    localparam int DEF_NUM_IMAGES   = 3;
    localparam int DEF_DWELL_FRAMES = 64;
    localparam int DEF_DEBOUNCE     = 4;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, level debounce, and a
// one-cycle pulse on each debounced 0->1 transition.
module btn_debounce
    import dot_scene_sequencer_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic div_clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic [1:0] sync_q;
    logic [3:0] cnt;
    logic       level;
    logic       level_d;

    // NOTE: non-blocking assignments in clocked logic, so every flop samples pre-edge values.
    always_ff @(posedge div_clk) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_d <= level;
            press   <= level & ~level_d;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == 4'(DEBOUNCE - 1)) begin
                cnt   <= '0;
                level <= sync_q[1];
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/dot_scene_sequencer.sv
// Image-select controller for the 8x8 dot display: manual, auto-cycling and
// paused modes, with every image change aligned to a frame_start edge.
module dot_scene_sequencer
    import dot_scene_sequencer_pkg::*;
#(
    parameter int NUM_IMAGES   = DEF_NUM_IMAGES,
    parameter int DWELL_FRAMES = DEF_DWELL_FRAMES,
    parameter int DEBOUNCE     = DEF_DEBOUNCE
) (
    input  logic       div_clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       btn_next,
    input  logic       btn_mode,
    input  logic       pause,
    output logic [1:0] state,
    output logic [1:0] mode,
    output logic       img_adv
);

    logic       next_press;
    logic       mode_press;
    mode_e      mode_q, mode_d;
    logic [7:0] dwell_q, dwell_d;
    logic       pending_q, pending_d;
    logic [1:0] state_d;
    logic       dwell_expire;
    logic       request;
    logic       advance;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_next (
        .div_clk (div_clk),
        .reset   (reset),
        .raw     (btn_next),
        .press   (next_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode (
        .div_clk (div_clk),
        .reset   (reset),
        .raw     (btn_mode),
        .press   (mode_press)
    );

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        mode_d = MODE_MANUAL;
        case (mode_q)
            MODE_MANUAL: mode_d = mode_press ? MODE_AUTO : MODE_MANUAL;
            MODE_AUTO: begin
                if (mode_press)  mode_d = MODE_MANUAL;
                else if (pause)  mode_d = MODE_PAUSED;
                else             mode_d = MODE_AUTO;
            end
            MODE_PAUSED: begin
                if (mode_press)  mode_d = MODE_MANUAL;
                else if (!pause) mode_d = MODE_AUTO;
                else             mode_d = MODE_PAUSED;
            end
            default:             mode_d = MODE_MANUAL;
        endcase

        dwell_expire = frame_start && (mode_q == MODE_AUTO) && (dwell_q == 8'(DWELL_FRAMES - 1));
        request      = next_press | dwell_expire;
        // A request landing on the frame_start cycle is served at that same edge.
        advance      = frame_start && (pending_q || request);

        dwell_d = dwell_q;
        if (mode_q == MODE_AUTO) begin
            if (next_press)
                dwell_d = '0;
            else if (frame_start)
                dwell_d = dwell_expire ? 8'd0 : dwell_q + 8'd1;
        end
        if (mode_d == MODE_MANUAL)
            dwell_d = '0;

        pending_d = advance ? 1'b0 : (pending_q | request);

        state_d = state;
        if (advance)
            state_d = (state >= 2'(NUM_IMAGES - 1)) ? 2'd0 : state + 2'd1;
    end

    always_ff @(posedge div_clk) begin
        if (!reset) begin
            mode_q    <= MODE_MANUAL;
            dwell_q   <= '0;
            pending_q <= 1'b0;
            state     <= '0;
            img_adv   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            dwell_q   <= dwell_d;
            pending_q <= pending_d;
            state     <= state_d;
            img_adv   <= advance;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_dot_scene_sequencer.sv
// Self-checking bench for dot_scene_sequencer: expected image advances are
// queued with their due edge and matched against each img_adv pulse.
module tb_dot_scene_sequencer;

    localparam int NUM_IMAGES   = 3;
    localparam int DWELL_FRAMES = 4;
    localparam int DEBOUNCE     = 2;

    logic       div_clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       btn_next;
    logic       btn_mode;
    logic       pause;
    logic [1:0] state;
    logic [1:0] mode;
    logic       img_adv;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned ecnt     = 0;
    int          phase    = 0;
    logic        last_fs  = 1'b0;

    typedef struct {
        logic [1:0]  st;
        int unsigned edge_n;
    } adv_t;

    adv_t       exp_q[$];
    adv_t       mon_e;
    logic [1:0] exp_state = 2'd0;
    logic [1:0] st_frozen;
    int unsigned e0;
    int unsigned e1;

    dot_scene_sequencer #(
        .NUM_IMAGES   (NUM_IMAGES),
        .DWELL_FRAMES (DWELL_FRAMES),
        .DEBOUNCE     (DEBOUNCE)
    ) dut (
        .div_clk     (div_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .btn_next    (btn_next),
        .btn_mode    (btn_mode),
        .pause       (pause),
        .state       (state),
        .mode        (mode),
        .img_adv     (img_adv)
    );

    always #5 div_clk = ~div_clk;

    // Scan-driver stand-in: frame_start high in every cycle whose phase is 0.
    initial begin
        frame_start = 1'b0;
        forever begin
            @(posedge div_clk);
            #1;
            last_fs     = frame_start;
            ecnt        = ecnt + 1;
            phase       = (phase + 1) % 8;
            frame_start = (phase == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge div_clk);
        #2;
    endtask

    task automatic sync_phase(input int p);
        while (phase != p) tick(1);
    endtask

    task automatic wait_edge(input int unsigned e);
        while (ecnt < e) tick(1);
    endtask

    task automatic push_adv(input int unsigned e);
        exp_state = (exp_state == 2'(NUM_IMAGES - 1)) ? 2'd0 : exp_state + 2'd1;
        exp_q.push_back('{exp_state, e});
    endtask

    // Clean press starting at phase p (1..3): the pulse reaches the sequencer
    // 6 edges later, and is served at the first frame edge from there on.
    task automatic press_next(input int p);
        sync_phase(p);
        push_adv(ecnt + 32'(9 - p));
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(8);
    endtask

    always @(negedge div_clk) begin
        if (img_adv === 1'b1) begin
            check("adv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("adv_state", 32'(state), 32'(mon_e.st));
                check("adv_edge", ecnt, mon_e.edge_n);
                check("adv_on_frame", 32'(last_fs), 32'd1);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        pause    = 1'b0;
        tick(1);

        for (int i = 0; i < 3; i++) begin
            btn_next = ~btn_next;
            btn_mode = ~btn_mode;
            pause    = ~pause;
            tick(1);
            check("rst_state", 32'(state), 32'd0);
            check("rst_mode", 32'(mode), 32'd0);
            check("rst_adv", 32'(img_adv), 32'd0);
        end
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        pause    = 1'b0;
        tick(12);
        check("idle_state", 32'(state), 32'd0);
        check("idle_mode", 32'(mode), 32'd0);

        // Manual stepping with wrap 0->1->2->0.
        for (int i = 0; i < 3; i++) press_next(1);
        check("wrap_state", 32'(state), 32'(exp_state));

        // One-cycle glitch must be rejected.
        sync_phase(1);
        btn_next = 1'b1;
        tick(1);
        btn_next = 1'b0;
        tick(24);
        check("glitch_state", 32'(state), 32'(exp_state));

        // Two debounced presses inside one frame collapse into one advance.
        sync_phase(4);
        push_adv(ecnt + 13);
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(2);
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(16);
        check("double_state", 32'(state), 32'(exp_state));

        // Press pulse on the frame_start cycle itself is served at once.
        press_next(3);
        check("coincide_state", 32'(state), 32'(exp_state));
        press_next(1);
        check("pre_auto_state", 32'(state), 32'd0);

        // AUTO: advance every 4 frames.
        sync_phase(1);
        e0 = ecnt;
        btn_mode = 1'b1;
        push_adv(e0 + 32);
        push_adv(e0 + 64);
        push_adv(e0 + 96);
        tick(10);
        btn_mode = 1'b0;
        check("auto_mode", 32'(mode), 32'd1);

        // Manual press two frames into a dwell restarts the dwell.
        wait_edge(e0 + 112);
        press_next(1);
        push_adv(e0 + 144);
        check("auto_mode2", 32'(mode), 32'd1);

        // Pause two frames into a dwell, hold for 10 frames, then resume.
        wait_edge(e0 + 160);
        pause     = 1'b1;
        st_frozen = exp_state;
        push_adv(e0 + 256);
        tick(2);
        check("pause_mode", 32'(mode), 32'd2);
        wait_edge(e0 + 224);
        check("pause_state", 32'(state), 32'(st_frozen));
        wait_edge(e0 + 240);
        pause = 1'b0;
        tick(2);
        check("resume_mode", 32'(mode), 32'd1);
        wait_edge(e0 + 258);
        check("resume_state", 32'(state), 32'(exp_state));

        // mode_press and pause on the same edge in AUTO: MANUAL wins.
        sync_phase(1);
        btn_mode = 1'b1;
        tick(5);
        pause = 1'b1;
        tick(1);
        check("simul_mode", 32'(mode), 32'd0);
        tick(5);
        btn_mode = 1'b0;
        tick(8);
        check("manual_pause_ignored", 32'(mode), 32'd0);
        pause = 1'b0;

        // Reset while an advance is pending discards it.
        press_next(1);
        check("pre_rst_state", 32'(state), 32'(exp_state));
        sync_phase(1);
        e1 = ecnt;
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        wait_edge(e1 + 6);
        reset = 1'b0;
        tick(2);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_adv", 32'(img_adv), 32'd0);
        reset     = 1'b1;
        exp_state = 2'd0;
        tick(30);
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_mode", 32'(mode), 32'd0);

        tick(4);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
